// File: rtl/window3x3_linebuf_pkg.sv
// win_pkg: tap indices, FSM state encoding and a ceil-log2 width helper
// shared by the window3x3_linebuf block and its testbench.
package win_pkg;

  // Tap k sits at oWin[k*DATA_W +: DATA_W]; row-major, top-left first.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_CC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;
  localparam int N_TAPS = 9;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Bits needed to hold 0..value-1; never less than one.
  function automatic int f_clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/window3x3_linebuf_if.sv
// Pixel-in / window-out handshake bundle for window3x3_linebuf.
// The producer/consumer side uses master, the block uses slave.
interface window3x3_linebuf_if #(
  parameter int DATA_W = 24
);
  logic                  iStart;
  logic                  iPixValid;
  logic                  oPixReady;
  logic [DATA_W-1:0]     iPixel;
  logic [9*DATA_W-1:0]   oWin;
  logic                  oValid;
  logic                  iReady;
  logic                  oBusy;
  logic                  oFrameDone;

  modport master (
    output iStart, iPixValid, iPixel, iReady,
    input  oPixReady, oWin, oValid, oBusy, oFrameDone
  );

  modport slave (
    input  iStart, iPixValid, iPixel, iReady,
    output oPixReady, oWin, oValid, oBusy, oFrameDone
  );
endinterface

// File: rtl/window3x3_linebuf_ram.sv
// linebuf_ram: one image line of pixels; asynchronous read and clocked write at
// the same column, so a read always returns the value from the previous row.
module linebuf_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 480,
  parameter int AW     = 9
) (
  input  logic              iClk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage is deliberately left without reset so it maps onto RAM
  // primitives; edge masking guarantees stale contents never reach a window.
  always_ff @(posedge iClk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window3x3_linebuf.sv
// window3x3_linebuf: streams a raster frame and emits one 3x3 neighbourhood per pixel.
// Zero padding by default; define WIN_EDGE_REPLICATE_EN for clamp-to-edge padding.
module window3x3_linebuf
  import win_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int WIDTH  = 480,
  parameter int HEIGHT = 272
) (
  input  logic iClk,
  input  logic iRst,
  window3x3_linebuf_if.slave bus
);

  localparam int XW = f_clog2(WIDTH + 1);
  localparam int YW = f_clog2(HEIGHT + 1);
  localparam int AW = f_clog2(WIDTH);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT);

  state_t                r_state;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic                  r_done;
  logic                  r_valid;
  logic [9*DATA_W-1:0]   r_win;
  logic [DATA_W-1:0]     r_sh [3][2];

  logic                  w_run;
  logic                  w_slot;
  logic                  w_col_real;
  logic                  w_real;
  logic                  w_adv;
  logic                  w_load;
  logic                  w_left;
  logic                  w_top;
`ifdef WIN_EDGE_REPLICATE_EN
  logic                  w_right;
  logic                  w_bottom;
`endif
  logic [AW-1:0]         w_addr;
  logic [DATA_W-1:0]     w_lb0_rd;
  logic [DATA_W-1:0]     w_lb1_rd;
  logic [DATA_W-1:0]     w_new [3];
  logic [DATA_W-1:0]     w_tap [N_TAPS];
  logic [9*DATA_W-1:0]   w_win_flat;

  // A position advances when it has data and the output slot can take a window.
  assign w_run      = (r_state == ST_RUN);
  assign w_slot     = !r_valid || bus.iReady;
  assign w_col_real = (r_x != X_LAST);
  assign w_real     = w_col_real && (r_y != Y_LAST);
  assign w_adv      = w_run && w_slot && (!w_real || bus.iPixValid);
  assign w_load     = w_adv && (r_x != '0) && (r_y != '0);
  assign w_left     = (r_x == XW'(1));
  assign w_top      = (r_y == YW'(1));
`ifdef WIN_EDGE_REPLICATE_EN
  assign w_right    = !w_col_real;
  assign w_bottom   = (r_y == Y_LAST);
`endif
  assign w_addr     = w_col_real ? r_x[AW-1:0] : '0;

  // lb0 holds row y-1 and lb1 holds row y-2 at the current column.
  linebuf_ram #(.DATA_W(DATA_W), .DEPTH(WIDTH), .AW(AW)) u_lb0 (
    .iClk    (iClk),
    .i_we    (w_adv && w_col_real),
    .i_addr  (w_addr),
    .i_wdata (w_new[2]),
    .o_rdata (w_lb0_rd)
  );

  linebuf_ram #(.DATA_W(DATA_W), .DEPTH(WIDTH), .AW(AW)) u_lb1 (
    .iClk    (iClk),
    .i_we    (w_adv && w_col_real),
    .i_addr  (w_addr),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  always_comb begin
    w_new[0] = w_col_real ? w_lb1_rd : '0;
    w_new[1] = w_col_real ? w_lb0_rd : '0;
    w_new[2] = w_real ? bus.iPixel : '0;
  end

  // The two retained columns plus the incoming column form the 3x3 window.
  always_comb begin
    // NOTE: every tap is assigned before any conditional override, so no latch
    // can form; blocking order lets later edge rules see earlier substitutions.
    for (int r = 0; r < 3; r++) begin
      w_tap[r*3]     = r_sh[r][0];
      w_tap[r*3 + 1] = r_sh[r][1];
      w_tap[r*3 + 2] = w_new[r];
    end
`ifdef WIN_EDGE_REPLICATE_EN
    if (w_left) begin
      w_tap[TAP_TL] = w_tap[TAP_TC];
      w_tap[TAP_ML] = w_tap[TAP_CC];
      w_tap[TAP_BL] = w_tap[TAP_BC];
    end
    if (w_right) begin
      w_tap[TAP_TR] = w_tap[TAP_TC];
      w_tap[TAP_MR] = w_tap[TAP_CC];
      w_tap[TAP_BR] = w_tap[TAP_BC];
    end
    if (w_top) begin
      w_tap[TAP_TL] = w_tap[TAP_ML];
      w_tap[TAP_TC] = w_tap[TAP_CC];
      w_tap[TAP_TR] = w_tap[TAP_MR];
    end
    if (w_bottom) begin
      w_tap[TAP_BL] = w_tap[TAP_ML];
      w_tap[TAP_BC] = w_tap[TAP_CC];
      w_tap[TAP_BR] = w_tap[TAP_MR];
    end
`else
    if (w_left) begin
      w_tap[TAP_TL] = '0;
      w_tap[TAP_ML] = '0;
      w_tap[TAP_BL] = '0;
    end
    if (w_top) begin
      w_tap[TAP_TL] = '0;
      w_tap[TAP_TC] = '0;
      w_tap[TAP_TR] = '0;
    end
`endif
  end

  always_comb begin
    w_win_flat = '0;
    for (int k = 0; k < N_TAPS; k++) w_win_flat[k*DATA_W +: DATA_W] = w_tap[k];
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int r = 0; r < 3; r++) begin
        r_sh[r][0] <= '0;
        r_sh[r][1] <= '0;
      end
    end else if (w_adv) begin
      for (int r = 0; r < 3; r++) begin
        r_sh[r][0] <= r_sh[r][1];
        r_sh[r][1] <= w_new[r];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.iStart) begin
            r_state <= ST_RUN;
            r_x     <= '0;
            r_y     <= '0;
          end
        end
        ST_RUN: begin
          if (w_adv) begin
            if (r_x == X_LAST) begin
              r_x <= '0;
              if (r_y == Y_LAST) begin
                r_y     <= '0;
                r_state <= ST_DRAIN;
              end else begin
                r_y <= r_y + YW'(1);
              end
            end else begin
              r_x <= r_x + XW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_valid && bus.iReady) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A held window stays put until the consumer takes it.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_win   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_win   <= w_win_flat;
      r_valid <= 1'b1;
    end else if (r_valid && bus.iReady) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.oWin       = r_win;
  assign bus.oValid     = r_valid;
  assign bus.oPixReady  = w_run && w_real && w_slot;
  assign bus.oFrameDone = r_done;
  assign bus.oBusy      = (r_state != ST_IDLE) || r_done;

endmodule

// File: tb/tb_window3x3_linebuf.sv
// Self-checking bench for window3x3_linebuf on a 4x3 frame; expected windows
// come from a direct neighbourhood model of the frame array.
module tb_window3x3_linebuf;
  import win_pkg::*;

  localparam int DW        = 24;
  localparam int W         = 4;
  localparam int H         = 3;
  localparam int NPIX      = W * H;
  localparam int WB        = 9 * DW;
  localparam int FRAME_CYC = (H + 1) * (W + 1) + 1;

`ifdef WIN_EDGE_REPLICATE_EN
  localparam int LIT_FIRST [9] = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
  localparam int LIT_LAST  [9] = '{7, 8, 8, 11, 12, 12, 11, 12, 12};
`else
  localparam int LIT_FIRST [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  localparam int LIT_LAST  [9] = '{7, 8, 0, 11, 12, 0, 0, 0, 0};
`endif

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  always #5 iClk = ~iClk;

  window3x3_linebuf_if #(.DATA_W(DW)) bus ();

  window3x3_linebuf #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [DW-1:0]   pix [NPIX];
  logic [WB-1:0]   got_q [$];
  int              acc_cnt;
  int              done_cnt;
  int              done_cyc;

  task automatic check_win(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Frame pixel at (y,x) with the out-of-frame rule applied.
  function automatic logic [DW-1:0] ref_pix(input int y, input int x);
`ifdef WIN_EDGE_REPLICATE_EN
    int yc, xc;
    yc = (y < 0) ? 0 : ((y >= H) ? H - 1 : y);
    xc = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
    return pix[yc*W + xc];
`else
    if (y < 0 || y >= H || x < 0 || x >= W) return '0;
    return pix[y*W + x];
`endif
  endfunction

  function automatic logic [WB-1:0] ref_win(input int n);
    logic [WB-1:0] w;
    int cy, cx;
    cy = n / W;
    cx = n % W;
    w  = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(dr*3 + dc)*DW +: DW] = ref_pix(cy + dr - 1, cx + dc - 1);
    return w;
  endfunction

  function automatic logic [WB-1:0] pack_taps(input int t [9]);
    logic [WB-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(t[k]);
    return w;
  endfunction

  function automatic logic [WB-1:0] win_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // Runs one frame: inputs change 1 time unit after a rising edge, the bench
  // samples handshakes on the falling edge. abort_after>0 stops after that many pixels.
  task automatic run_frame(input int valid_pct, input int ready_pct, input int stall_at,
                           input int restart_at, input int abort_after);
    logic [WB-1:0] snap;
    bit in_stall;
    got_q.delete();
    acc_cnt  = 0;
    done_cnt = 0;
    done_cyc = -1;
    snap     = '0;
    @(posedge iClk); #1;
    bus.iStart = 1'b1;
    @(posedge iClk); #1;
    bus.iStart = 1'b0;
    check_bit("busy_after_start", bus.oBusy, 1'b1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_stall      = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
      bus.iStart    = (cyc == restart_at);
      bus.iPixValid = (acc_cnt < NPIX) && ($urandom_range(99) < valid_pct);
      bus.iPixel    = (acc_cnt < NPIX) ? pix[acc_cnt] : DW'($urandom);
      bus.iReady    = !in_stall && ($urandom_range(99) < ready_pct);
      @(negedge iClk);
      if (in_stall) begin
        if (cyc == stall_at) begin
          snap = bus.oWin;
          check_bit("stall_valid_at_entry", bus.oValid, 1'b1);
        end else begin
          check_win("stall_win_frozen", bus.oWin, snap);
          check_bit("stall_valid_frozen", bus.oValid, 1'b1);
        end
        check_bit("stall_pixready_low", bus.oPixReady, 1'b0);
      end
      if (bus.oValid && bus.iReady) got_q.push_back(bus.oWin);
      if (bus.iPixValid && bus.oPixReady) acc_cnt++;
      if (bus.oFrameDone) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check_bit("busy_at_done", bus.oBusy, 1'b1);
          check_bit("valid_at_done", bus.oValid, 1'b0);
        end
      end
      @(posedge iClk); #1;
      if (abort_after > 0 && acc_cnt >= abort_after) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    bus.iStart    = 1'b0;
    bus.iPixValid = 1'b0;
    bus.iReady    = 1'b1;
  endtask

  task automatic check_frame(input string tag, input bit timed);
    check_bit({tag, "_done_seen"}, done_cyc >= 0, 1'b1);
    check_int({tag, "_nwin"}, got_q.size(), NPIX);
    for (int i = 0; i < NPIX; i++)
      check_win($sformatf("%s_win%0d", tag, i), win_at(i), ref_win(i));
    check_int({tag, "_done_cnt"}, done_cnt, 1);
    check_int({tag, "_npix"}, acc_cnt, NPIX);
    check_bit({tag, "_busy_end"}, bus.oBusy, 1'b0);
    if (timed) check_int({tag, "_cycles"}, done_cyc, FRAME_CYC);
  endtask

  task automatic check_outputs_clear(input string tag);
    check_win({tag, "_win"}, bus.oWin, '0);
    check_bit({tag, "_valid"}, bus.oValid, 1'b0);
    check_bit({tag, "_pixready"}, bus.oPixReady, 1'b0);
    check_bit({tag, "_busy"}, bus.oBusy, 1'b0);
    check_bit({tag, "_done"}, bus.oFrameDone, 1'b0);
  endtask

  initial begin
    bus.iStart    = 1'b0;
    bus.iPixValid = 1'b0;
    bus.iPixel    = '0;
    bus.iReady    = 1'b1;
    acc_cnt       = 0;
    done_cnt      = 0;
    done_cyc      = -1;

    // Power-on reset.
    repeat (3) @(posedge iClk);
    #1;
    check_outputs_clear("por");
    @(negedge iClk);
    iRst = 1'b1;

    // Continuous streaming, pixels 1..12.
    for (int i = 0; i < NPIX; i++) pix[i] = DW'(i + 1);
    run_frame(100, 100, -1, -1, 0);
    check_frame("stream", 1'b1);
    check_win("lit_first", win_at(0), pack_taps(LIT_FIRST));
    check_win("lit_last", win_at(NPIX - 1), pack_taps(LIT_LAST));

    // Consumer stalls for five cycles mid-frame.
    run_frame(100, 100, 8, -1, 0);
    check_frame("stall", 1'b0);

    // Random input gaps, same pixels.
    run_frame(55, 100, -1, -1, 0);
    check_frame("gaps", 1'b0);

    // Random pixel values with random gaps on both sides.
    for (int i = 0; i < NPIX; i++) pix[i] = DW'($urandom);
    run_frame(70, 65, -1, -1, 0);
    check_frame("rand", 1'b0);

    // Reset after six pixels, then a clean frame.
    for (int i = 0; i < NPIX; i++) pix[i] = DW'(i + 1);
    run_frame(100, 100, -1, -1, 6);
    check_int("abort_npix", acc_cnt, 6);
    iRst = 1'b0;
    #2;
    check_outputs_clear("midrst");
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    run_frame(100, 100, -1, -1, 0);
    check_frame("after_rst", 1'b1);

    // A second iStart while busy must be ignored.
    run_frame(100, 100, -1, 10, 0);
    check_frame("restart", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
